// File: rtl/forward_hazard_unit_pkg.sv
// Shared CPU definitions for the forwarding/hazard block: widths, forward select
// encoding and the hazard tracker entry layout.
package forward_hazard_unit_pkg;

    localparam int unsigned CPU_XLEN = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [1:0] {
        FwdRf    = 2'b00,
        FwdExMem = 2'b01,
        FwdMemWb = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [CNT_W-1:0]  cnt;
    } trk_entry_t;

endpackage

// File: rtl/forward_hazard_unit_tracker.sv
// Tracks in-flight writers whose result is not yet usable and flags any ID source
// register that still depends on one of them.
module hazard_tracker
    import forward_hazard_unit_pkg::*;
#(
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned NUM_SRC = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        alloc,
    input  logic [REG_AW-1:0]           alloc_rd,
    input  logic [CNT_W-1:0]            alloc_cnt,
    input  logic [NUM_SRC*REG_AW-1:0]   rs,
    output logic [NUM_SRC-1:0]          hit
);

    trk_entry_t [DEPTH-1:0] ent_q, ent_d;
    logic                   placed;
    logic [REG_AW-1:0]      src_addr;

    // Age first, then allocate into a slot that is free after aging, so an entry
    // expiring on this edge can be reused by the same edge's allocation.
    always_comb begin
        ent_d  = ent_q;
        placed = 1'b0;
        for (int e = 0; e < int'(DEPTH); e++) begin
            if (ent_q[e].valid) begin
                ent_d[e].cnt = ent_q[e].cnt - CNT_W'(1);
                if (ent_q[e].cnt <= CNT_W'(1)) begin
                    ent_d[e].valid = 1'b0;
                end
            end
        end
        if (alloc) begin
            for (int e = 0; e < int'(DEPTH); e++) begin
                if (!placed && !ent_d[e].valid) begin
                    ent_d[e] = '{valid: 1'b1, rd: alloc_rd, cnt: alloc_cnt};
                    placed   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        hit      = '0;
        src_addr = '0;
        for (int s = 0; s < int'(NUM_SRC); s++) begin
            src_addr = rs[s*REG_AW +: REG_AW];
            if (src_addr != '0) begin
                for (int e = 0; e < int'(DEPTH); e++) begin
                    if (ent_q[e].valid && ent_q[e].rd == src_addr) begin
                        hit[s] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// Operand bypass muxes for the EX stage plus load-use / writeback stall generation
// and a saturating stall-cycle counter.
module forward_hazard_unit
    import forward_hazard_unit_pkg::*;
#(
    parameter int unsigned XLEN    = CPU_XLEN,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned LD_LAT  = 1,
    parameter int unsigned FWD_EN  = 1,
    parameter int unsigned WB_LAT  = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
    input  logic                        id_valid,
    input  logic [REG_AW-1:0]           id_rd,
    input  logic                        id_rw,
    input  logic                        id_is_load,
    input  logic [NUM_SRC*REG_AW-1:0]   ex_rs,
    input  logic [NUM_SRC*XLEN-1:0]     ex_rf_data,
    input  logic [REG_AW-1:0]           ex_mem_rd,
    input  logic                        ex_mem_rw,
    input  logic [XLEN-1:0]             ex_mem_result,
    input  logic [REG_AW-1:0]           mem_wb_rd,
    input  logic                        mem_wb_rw,
    input  logic                        mem_wb_to_reg,
    input  logic [XLEN-1:0]             mem_wb_read_data,
    input  logic [XLEN-1:0]             mem_wb_result,
    output logic [NUM_SRC*XLEN-1:0]     fwd_data,
    output logic                        stall,
    output logic                        bubble,
    output logic [15:0]                 stall_cnt
);

    localparam int unsigned DEPTH = (LD_LAT > WB_LAT) ? LD_LAT : WB_LAT;

    logic [NUM_SRC-1:0] src_hit;
    logic               issue;
    logic               alloc;
    logic [CNT_W-1:0]   alloc_cnt;
    logic [15:0]        stall_cnt_q, stall_cnt_d;
    logic [XLEN-1:0]    mem_wb_val;
    logic [REG_AW-1:0]  ex_addr;
    fwd_sel_e           fwd_sel [NUM_SRC];

    assign stall     = id_valid && (|src_hit);
    assign bubble    = stall;
    assign issue     = id_valid && !stall;
    assign stall_cnt = stall_cnt_q;

    // With bypass only loads leave a gap; without it every writer is pending until WB.
    always_comb begin
        alloc     = 1'b0;
        alloc_cnt = '0;
        if (issue && id_rw && id_rd != '0) begin
            if (FWD_EN == 0) begin
                alloc     = 1'b1;
                alloc_cnt = CNT_W'(WB_LAT);
            end else if (id_is_load) begin
                alloc     = 1'b1;
                alloc_cnt = CNT_W'(LD_LAT);
            end
        end
    end

    hazard_tracker #(
        .DEPTH   (DEPTH),
        .NUM_SRC (NUM_SRC)
    ) u_tracker (
        .clk       (clk),
        .reset     (reset),
        .alloc     (alloc),
        .alloc_rd  (id_rd),
        .alloc_cnt (alloc_cnt),
        .rs        (id_rs),
        .hit       (src_hit)
    );

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_wb_val = mem_wb_to_reg ? mem_wb_read_data : mem_wb_result;

    // EX/MEM is the younger producer, so it takes priority over MEM/WB.
    always_comb begin
        ex_addr = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            fwd_sel[i] = FwdRf;
            ex_addr    = ex_rs[i*REG_AW +: REG_AW];
            if (FWD_EN != 0 && ex_addr != '0) begin
                if (ex_mem_rw && ex_addr == ex_mem_rd) begin
                    fwd_sel[i] = FwdExMem;
                end else if (mem_wb_rw && ex_addr == mem_wb_rd) begin
                    fwd_sel[i] = FwdMemWb;
                end
            end
        end
    end

    always_comb begin
        fwd_data = ex_rf_data;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            case (fwd_sel[i])
                FwdExMem: fwd_data[i*XLEN +: XLEN] = ex_mem_result;
                FwdMemWb: fwd_data[i*XLEN +: XLEN] = mem_wb_val;
                default:  fwd_data[i*XLEN +: XLEN] = ex_rf_data[i*XLEN +: XLEN];
            endcase
        end
    end

endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NUM_SRC, default 2, number of source-operand ports (1..3).
REQ-003 SHALL have parameter LD_LAT, default 1, cycles after issue before load data is forwardable (1..4).
REQ-004 SHALL have parameter FWD_EN, default 1; 1 = bypass mode, 0 = stall-until-writeback mode.
REQ-005 SHALL have parameter WB_LAT, default 3, cycles after issue before regfile read returns the new value (used when FWD_EN=0).
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 id_rs  in  NUM_SRC*5  ID-stage source register addresses, port i at [5i+4:5i].
REQ-010 id_valid  in  1  ID holds a valid instruction.
REQ-011 id_rd, id_rw, id_is_load  in  5, 1, 1  ID instruction destination, write enable, load flag.
REQ-012 ex_rs, ex_rf_data  in  NUM_SRC*5, NUM_SRC*XLEN  EX-stage source addresses and register-file values.
REQ-013 ex_mem_rd, ex_mem_rw, ex_mem_result  in  5, 1, XLEN  EX/MEM write-back info.
REQ-014 mem_wb_rd, mem_wb_rw, mem_wb_to_reg, mem_wb_read_data, mem_wb_result  in  5, 1, 1, XLEN, XLEN  MEM/WB write-back info.
REQ-015 fwd_data  out  NUM_SRC*XLEN  resolved operand per source port.
REQ-016 stall  out  1  hold PC and IF/ID this cycle.
REQ-017 bubble  out  1  insert NOP into ID/EX this cycle.
REQ-018 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-019 Issue SHALL occur on a clock edge where id_valid=1 and stall=0.
REQ-020 FWD_EN=1: fwd_data[i] SHALL select ex_mem_result if ex_mem_rw and ex_rs[i]==ex_mem_rd!=0, else MEM/WB value (mem_wb_to_reg ? read_data : result) if mem_wb_rw and ex_rs[i]==mem_wb_rd!=0, else ex_rf_data[i]; combinational.
REQ-021 FWD_EN=0: fwd_data[i] SHALL equal ex_rf_data[i].
REQ-022 Source address 0 SHALL never forward or stall.
REQ-023 Tracker SHALL hold up to max(LD_LAT,WB_LAT) entries {valid, rd, count}; on issue with id_rw=1 and id_rd!=0 it SHALL allocate count=LD_LAT if FWD_EN=1 and id_is_load=1, count=WB_LAT if FWD_EN=0, else nothing.
REQ-024 Every cycle each valid entry SHALL decrement count; an entry reaching 0 SHALL be invalidated that edge.
REQ-025 stall SHALL be 1 when id_valid=1 and any id_rs[i]!=0 matches any valid entry rd; combinational from tracker state.
REQ-026 bubble SHALL equal stall; no allocation occurs on a stalled cycle.
REQ-027 Allocation and expiry on the same edge SHALL both take effect; tracker SHALL never overflow, since one allocation per cycle and each entry lives at most depth cycles.
REQ-028 Two entries with the same rd SHALL be allowed; stall holds until the youngest expires.
REQ-029 stall_cnt SHALL increment on each cycle with stall=1 and saturate at 16'hFFFF.
REQ-030 Classic LD_LAT=1, FWD_EN=1 SHALL give exactly one stall cycle for load-use.

Reset
REQ-031 reset=1 SHALL clear all tracker valids and stall_cnt to 0 at the next edge, overriding a simultaneous issue.
REQ-032 After reset, stall=0 and bubble=0; fwd_data follows inputs (combinational).
REQ-033 Reset mid-stall SHALL drop all pending hazards; the first cycle after reset has stall=0.

Structure
REQ-034 XLEN, register-address width 5, and the forward select encoding (00 rf, 01 EX/MEM, 10 MEM/WB) SHALL live in the shared cpu package/header.
REQ-035 The tracker SHALL be a sub-module hazard_tracker (allocate, age, match NUM_SRC addresses); forwarding muxes stay in the top.

Verification
REQ-036 LD_LAT=1: lw x5 issued, next ID reads x5 -> stall=1 for 1 cycle, then EX operand = mem_wb_read_data 0xDEADBEEF.
REQ-037 ALU back-to-back: add x3 then sub reads x3, ex_mem_result=0x12 -> no stall, fwd_data=0x12; EX/MEM wins over MEM/WB=0x34 for same rd.
REQ-038 LD_LAT=3: load x7, dependent next -> exactly 3 stall cycles, stall_cnt=3.
REQ-039 FWD_EN=0, WB_LAT=3: add x4, then reader of x4 -> 3 stalls; reader of x0 or x9 -> 0 stalls.
REQ-040 Reset asserted during second stall cycle of LD_LAT=3 -> stall=0 after edge, stall_cnt=0.
REQ-041 Force 70000 stall cycles -> stall_cnt holds 0xFFFF.
